// File: rtl/port_uart_pkg.sv
// port_uart_pkg: register map, STATUS bit positions and FSM state types shared by the UART port
package port_uart_pkg;
    localparam logic [7:0] REG_DATA   = 8'd0;
    localparam logic [7:0] REG_STATUS = 8'd1;
    localparam logic [7:0] REG_CTRL   = 8'd2;
    localparam int ST_TX_EMPTY   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_RX_OVERRUN = 3;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
endpackage

// File: rtl/port_uart_fifo4.sv
// port_uart_fifo4: 8-bit, 4-deep FIFO; a push while full is accepted only if a pop happens in the same cycle
module port_uart_fifo4 (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] pushData,
    input  logic       pop,
    output logic [7:0] popData,
    output logic       full,
    output logic       empty
);
    logic [7:0] mem [4];
    logic [1:0] wrPtr, rdPtr;
    logic [2:0] count;
    logic doPush, doPop;
    assign full    = count == 3'd4;
    assign empty   = count == 3'd0;
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr];
    // pointers wrap modulo 4 through their 2-bit width; count tracks occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 2'd1;
            if (doPop) rdPtr <= rdPtr + 2'd1;
            count <= count + {2'b0, doPush} - {2'b0, doPop};
        end
    end
    // storage needs no reset; only the pointers define its contents
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end
endmodule

// File: rtl/port_uart.sv
// port_uart: CPU I/O-port mapped 8N1 UART with 4-deep TX FIFO, single-byte RX holding register and RX interrupt
module port_uart import port_uart_pkg::*; #(
    parameter logic [7:0] BASE_ADDR    = 8'hE0,
    parameter int         CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] portAddress,
    input  logic       portRead,
    input  logic       portWrite,
    input  logic [7:0] portWrData,
    output logic [7:0] portRdData,
    output logic       intReq,
    output logic       txd,
    input  logic       rxd
);
    localparam logic [7:0] BIT_END  = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_END = 8'(CLKS_PER_BIT / 2 - 1);
    logic isData, isStatus, isCtrl, dataRead, dataWrite, ctrlWrite;
    logic rxIE, rxValid, rxOverrun;
    logic [7:0] rxData, statusByte, fifoData;
    logic txFull, txEmpty, fifoEmpty, txPop, txdNext;
    txState_t txState, txNext;
    logic [7:0] txBaud, txBaudNext, txShift, txShiftNext;
    logic [2:0] txBit, txBitNext;
    rxState_t rxState, rxNext;
    logic [7:0] rxBaud, rxBaudNext, rxShift, rxShiftNext;
    logic [2:0] rxBit, rxBitNext;
    logic rxMeta, rxSync, rxPrev, rxDone;
    assign isData    = portAddress == BASE_ADDR + REG_DATA;
    assign isStatus  = portAddress == BASE_ADDR + REG_STATUS;
    assign isCtrl    = portAddress == BASE_ADDR + REG_CTRL;
    assign dataRead  = portRead && isData;
    assign dataWrite = portWrite && isData;
    assign ctrlWrite = portWrite && isCtrl;
    assign txEmpty   = fifoEmpty && txState == TX_IDLE;
    // combinational read mux so the CPU samples the register at the same edge as its strobe
    always_comb begin
        statusByte = 8'h00;
        statusByte[ST_TX_EMPTY] = txEmpty;
        statusByte[ST_TX_FULL] = txFull;
        statusByte[ST_RX_VALID] = rxValid;
        statusByte[ST_RX_OVERRUN] = rxOverrun;
        portRdData = isData ? rxData : isStatus ? statusByte : isCtrl ? {7'b0, rxIE} : 8'h00;
    end
    port_uart_fifo4 txFifo (
        .clk(clk),
        .reset(reset),
        .push(dataWrite),
        .pushData(portWrData),
        .pop(txPop),
        .popData(fifoData),
        .full(txFull),
        .empty(fifoEmpty)
    );
    // TX state, counters and a registered txd so the line is glitch-free and idles high out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            txState <= TX_IDLE;
            txBaud  <= '0;
            txBit   <= '0;
            txShift <= '0;
            txd     <= 1'b1;
        end else begin
            txState <= txNext;
            txBaud  <= txBaudNext;
            txBit   <= txBitNext;
            txShift <= txShiftNext;
            txd     <= txdNext;
        end
    end
    // TX next state: STOP chains straight into START when more data waits, giving gap-free frames
    always_comb begin
        txNext = txState;
        txBaudNext = txBaud + 8'd1;
        txBitNext = txBit;
        txShiftNext = txShift;
        txPop = 1'b0;
        case (txState)
            TX_IDLE: begin
                txBaudNext = '0;
                if (!fifoEmpty) begin
                    txNext = TX_START;
                    txPop = 1'b1;
                    txShiftNext = fifoData;
                end
            end
            TX_START: if (txBaud == BIT_END) begin
                txNext = TX_DATA;
                txBaudNext = '0;
                txBitNext = '0;
            end
            TX_DATA: if (txBaud == BIT_END) begin
                txBaudNext = '0;
                txShiftNext = txShift >> 1;
                txBitNext = txBit + 3'd1;
                if (txBit == 3'd7) txNext = TX_STOP;
            end
            TX_STOP: if (txBaud == BIT_END) begin
                txBaudNext = '0;
                txNext = fifoEmpty ? TX_IDLE : TX_START;
                txPop = !fifoEmpty;
                txShiftNext = fifoEmpty ? txShift : fifoData;
            end
            default: txNext = TX_IDLE;
        endcase
        txdNext = txNext == TX_START ? 1'b0 : txNext == TX_DATA ? txShiftNext[0] : 1'b1;
    end
    // two-flop synchronizer for the asynchronous rxd, plus one more stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= rxd;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end
    // RX state and counters; reset drops any partial frame
    always_ff @(posedge clk) begin
        if (reset) begin
            rxState <= RX_IDLE;
            rxBaud  <= '0;
            rxBit   <= '0;
            rxShift <= '0;
        end else begin
            rxState <= rxNext;
            rxBaud  <= rxBaudNext;
            rxBit   <= rxBitNext;
            rxShift <= rxShiftNext;
        end
    end
    // RX next state: re-check start at half a bit, then sample every full bit so data lands mid-bit
    always_comb begin
        rxNext = rxState;
        rxBaudNext = rxBaud + 8'd1;
        rxBitNext = rxBit;
        rxShiftNext = rxShift;
        rxDone = 1'b0;
        case (rxState)
            RX_IDLE: begin
                rxBaudNext = '0;
                if (rxPrev && !rxSync) rxNext = RX_START;
            end
            RX_START: if (rxBaud == HALF_END) begin
                rxBaudNext = '0;
                rxBitNext = '0;
                rxNext = rxSync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rxBaud == BIT_END) begin
                rxBaudNext = '0;
                rxShiftNext = {rxSync, rxShift[7:1]};
                rxBitNext = rxBit + 3'd1;
                if (rxBit == 3'd7) rxNext = RX_STOP;
            end
            RX_STOP: if (rxBaud == BIT_END) begin
                rxBaudNext = '0;
                rxNext = RX_IDLE;
                rxDone = rxSync;
            end
            default: rxNext = RX_IDLE;
        endcase
    end
    // CPU-visible RX/CTRL registers; a DATA read in the completing cycle frees the slot for the new byte
    always_ff @(posedge clk) begin
        if (reset) begin
            rxIE      <= 1'b0;
            rxValid   <= 1'b0;
            rxOverrun <= 1'b0;
            rxData    <= 8'h00;
            intReq    <= 1'b0;
        end else begin
            intReq <= rxIE & rxValid;
            if (ctrlWrite) begin
                rxIE <= portWrData[0];
                if (portWrData[1]) rxOverrun <= 1'b0;
            end
            if (dataRead) rxValid <= 1'b0;
            if (rxDone) begin
                if (!rxValid || dataRead) begin
                    rxData  <= rxShift;
                    rxValid <= 1'b1;
                end else begin
                    rxOverrun <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_port_uart.sv
// tb_port_uart: randomized scoreboard bench for port_uart with a frame-level TX/RX reference model
module tb_port_uart;
    localparam int CPB = 4;
    localparam logic [7:0] A_DATA = 8'hE0;
    localparam logic [7:0] A_STATUS = 8'hE1;
    localparam logic [7:0] A_CTRL = 8'hE2;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] portAddress = 8'h00;
    logic portRead = 1'b0;
    logic portWrite = 1'b0;
    logic [7:0] portWrData = 8'h00;
    logic [7:0] portRdData;
    logic intReq, txd;
    logic rxd = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] txExp[$];
    logic [7:0] rxExp[$];
    int startCyc[$];
    bit txMonOn = 1'b0;
    logic mValid = 1'b0, mOverrun = 1'b0, mIE = 1'b0;
    logic [39:0] txGot, txWant;
    logic [7:0] txByte;
    int txStart;
    bit txAbort;

    port_uart #(.BASE_ADDR(8'hE0), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .reset(reset),
        .portAddress(portAddress),
        .portRead(portRead),
        .portWrite(portWrite),
        .portWrData(portWrData),
        .portRdData(portRdData),
        .intReq(intReq),
        .txd(txd),
        .rxd(rxd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReg(input string name, input logic [7:0] addr, input logic [7:0] exp);
        portAddress = addr;
        @(negedge clk);
        check(name, portRdData, exp);
        tick();
    endtask

    function automatic logic [7:0] expStatus(input logic [1:0] tx);
        return {4'b0, mOverrun, mValid, tx};
    endfunction

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        portAddress = addr;
        portWrData = data;
        portWrite = 1'b1;
        tick();
        portWrite = 1'b0;
    endtask

    task automatic txWrite(input logic [7:0] data);
        wr(A_DATA, data);
        txExp.push_back(data);
    endtask

    task automatic readData();
        portAddress = A_DATA;
        portRead = 1'b1;
        tick();
        portRead = 1'b0;
        mValid = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic stopBit);
        rxd = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (CPB) tick();
        end
        rxd = stopBit;
        repeat (CPB) tick();
        rxd = 1'b1;
    endtask

    task automatic sendRx(input logic [7:0] data, input logic stopBit);
        sendFrame(data, stopBit);
        repeat (6) tick();
        if (stopBit) begin
            if (!mValid) begin
                rxExp.push_back(data);
                mValid = 1'b1;
            end else begin
                mOverrun = 1'b1;
            end
        end
    endtask

    task automatic waitTxDone(input string name);
        for (int i = 0; i < 3000 && txExp.size() != 0; i++) tick();
        check(name, txExp.size(), 0);
        repeat (2) tick();
    endtask

    // TX monitor: capture 10 bit cells of CPB samples each and compare with the next queued byte
    initial begin
        forever begin
            @(negedge clk);
            if (txMonOn && txd === 1'b0) begin
                txStart = cyc;
                txGot = '0;
                txGot[0] = txd;
                txAbort = 1'b0;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clk);
                    if (!txMonOn) begin
                        txAbort = 1'b1;
                        break;
                    end
                    txGot[i] = txd;
                end
                if (!txAbort) begin
                    startCyc.push_back(txStart);
                    checks++;
                    if (txExp.size() == 0) begin
                        errors++;
                        $display("FAIL tx_unexpected: frame samples %0h seen, no byte expected", txGot);
                    end else begin
                        checks--;
                        txByte = txExp.pop_front();
                        for (int i = 0; i < 40; i++) begin
                            int b;
                            b = i / CPB;
                            txWant[i] = b == 0 ? 1'b0 : b == 9 ? 1'b1 : txByte[b - 1];
                        end
                        check("tx_frame", txGot, txWant);
                    end
                end
            end
        end
    end

    // RX monitor: every DATA read strobe must return the oldest byte the model accepted
    initial begin
        forever begin
            @(negedge clk);
            if (portRead && portAddress == A_DATA) begin
                if (rxExp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected_read: got %0h, no byte expected", portRdData);
                end else begin
                    check("rx_data", portRdData, rxExp.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within 500000 time units");
        $fatal(1);
    end

    initial begin
        int k;
        bit found;
        logic [7:0] r;
        repeat (3) tick();
        @(negedge clk);
        check("reset_txd", txd, 1);
        check("reset_intReq", intReq, 0);
        tick();
        checkReg("reset_status", A_STATUS, 8'h01);
        checkReg("reset_data", A_DATA, 8'h00);
        checkReg("reset_ctrl", A_CTRL, 8'h00);
        checkReg("unmapped", 8'hE3, 8'h00);
        reset = 1'b0;
        tick();
        txMonOn = 1'b1;

        txWrite(8'hA5);
        checkReg("tx_busy_status", A_STATUS, 8'h00);
        waitTxDone("tx_a5_done");
        checkReg("tx_idle_status", A_STATUS, 8'h01);

        startCyc.delete();
        portAddress = A_DATA;
        portWrite = 1'b1;
        for (int i = 0; i < 6; i++) begin
            portWrData = 8'h30 + 8'(i);
            if (i < 5) txExp.push_back(portWrData);
            tick();
        end
        portWrite = 1'b0;
        checkReg("tx_full_status", A_STATUS, 8'h02);
        waitTxDone("tx_burst_done");
        repeat (60) tick();
        check("tx_burst_frames", startCyc.size(), 5);
        for (int i = 1; i < startCyc.size(); i++) check("tx_gap", startCyc[i] - startCyc[i - 1], 40);

        wr(A_CTRL, 8'h01);
        mIE = 1'b1;
        checkReg("ctrl_read", A_CTRL, 8'h01);
        sendFrame(8'h3C, 1'b1);
        rxExp.push_back(8'h3C);
        mValid = 1'b1;
        portAddress = A_STATUS;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (portRdData[2]) begin
                found = 1'b1;
                break;
            end
        end
        check("rx_valid_seen", found, 1);
        check("int_lag", intReq, 0);
        @(negedge clk);
        check("int_set", intReq, 1);
        tick();
        readData();
        tick();
        @(negedge clk);
        check("int_clear", intReq, 0);
        tick();
        checkReg("after_read_status", A_STATUS, expStatus(2'b01));

        wr(A_CTRL, 8'h00);
        mIE = 1'b0;
        sendRx(8'h81, 1'b1);
        sendRx(8'h7E, 1'b1);
        checkReg("overrun_status", A_STATUS, expStatus(2'b01));
        check("overrun_no_int", intReq, 0);
        readData();
        checkReg("overrun_kept", A_STATUS, expStatus(2'b01));
        wr(A_CTRL, 8'h02);
        mOverrun = 1'b0;
        checkReg("overrun_cleared", A_STATUS, expStatus(2'b01));

        rxd = 1'b0;
        tick();
        rxd = 1'b1;
        repeat (60) tick();
        checkReg("glitch_status", A_STATUS, expStatus(2'b01));
        sendRx(8'h55, 1'b0);
        checkReg("framing_status", A_STATUS, expStatus(2'b01));
        sendRx(8'hC3, 1'b1);
        readData();

        for (int n = 0; n < 6; n++) begin
            k = int'($urandom_range(1, 4));
            for (int j = 0; j < k; j++) txWrite(8'($urandom));
            r = 8'($urandom);
            mIE = 1'($urandom);
            wr(A_CTRL, {7'b0, mIE});
            sendRx(r, 1'b1);
            check("rand_int", intReq, mIE);
            readData();
            waitTxDone("rand_tx_done");
            checkReg("rand_status", A_STATUS, expStatus(2'b01));
        end

        txWrite(8'h5A);
        repeat (12) tick();
        txMonOn = 1'b0;
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("reset_mid_txd", txd, 1);
        tick();
        reset = 1'b0;
        txExp.delete();
        mValid = 1'b0;
        mOverrun = 1'b0;
        mIE = 1'b0;
        checkReg("reset_mid_status", A_STATUS, 8'h01);
        txMonOn = 1'b1;
        txWrite(8'h96);
        waitTxDone("post_reset_tx");

        check("rx_queue_empty", rxExp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
